// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit path.
package i2s_pkg;

   localparam int AUDIO_WIDTH_DEF = 24;

   // Default-width stereo frame; left sample occupies the upper half.
   typedef struct packed {
      logic [AUDIO_WIDTH_DEF-1:0] l;
      logic [AUDIO_WIDTH_DEF-1:0] r;
   } stereo_frame_t;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tx_state_e;

   function automatic int frame_bits(input int slot_w);
      return 2 * slot_w;
   endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous FIFO holding packed {left, right} frames, with occupancy count.
module audio_frame_fifo #(
   parameter int DATA_W = 48,
   parameter int DEPTH  = 4
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count_q;
   logic              push;
   logic              pop;

   // Ready comes from the registered count, so a full FIFO refuses even on a pop cycle.
   assign wr_ready = (count_q < (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign push     = wr_valid && wr_ready;
   assign pop      = rd_en && !empty;
   assign rd_data  = mem[rd_ptr];
   assign count    = count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count_q <= count_q + 1'b1;
         else if (pop && !push)
            count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/i2s_tx_out.sv
// Stereo I2S master transmitter: frame FIFO, BCLK/LRCLK generation, MSB-first serializer.
// Define I2S_TX_HOLD_ON_UNDERRUN_EN to repeat the last frame on underrun instead of zeros.
module i2s_tx_out
   import i2s_pkg::*;
#(
   parameter int I2S_WIDTH    = 24,
   parameter int AUDIO_WIDTH  = 24,
   parameter int BUFFER_DEPTH = 4,
   parameter int BCLK_DIV     = 4
)(
   input  logic                            sys_clk,
   input  logic                            sys_rst_n,
   input  logic                            tx_enable,
   input  logic [AUDIO_WIDTH-1:0]          sample_in_l,
   input  logic [AUDIO_WIDTH-1:0]          sample_in_r,
   input  logic                            sample_wr_valid,
   output logic                            sample_wr_ready,
   output logic                            i2s_bclk,
   output logic                            i2s_lrclk,
   output logic                            i2s_data,
   output logic [$clog2(BUFFER_DEPTH):0]   buffer_count,
   output logic                            buffer_empty,
   output logic                            underrun,
   input  logic                            underrun_clr
);

   localparam int FRAME_BITS = frame_bits(I2S_WIDTH);
   localparam int PW         = $clog2(FRAME_BITS);
   localparam int DW         = $clog2(BCLK_DIV);
   localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_BITS - 1);
   localparam logic [PW-1:0] LEFT_LAST = PW'(I2S_WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);

   if (AUDIO_WIDTH > I2S_WIDTH) begin : g_width_chk
      $error("AUDIO_WIDTH must not exceed I2S_WIDTH");
   end
   if (BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("BUFFER_DEPTH must be a power of 2 and at least 2");
   end
   if (BCLK_DIV < 2) begin : g_div_chk
      $error("BCLK_DIV must be at least 2");
   end

   tx_state_e               state, state_d;
   logic [DW-1:0]           div_cnt, div_cnt_d;
   logic [PW-1:0]           bit_pos, bit_pos_d, next_pos;
   logic [FRAME_BITS-1:0]   shift_reg, shift_reg_d;
   logic [FRAME_BITS-1:0]   fifo_frame, load_frame, underrun_frame;
   logic [I2S_WIDTH-1:0]    slot_l, slot_r;
   logic [2*AUDIO_WIDTH-1:0] fifo_rd;
   logic                    bclk_d, lrclk_d, data_d, underrun_d;
   logic                    fifo_pop, bclk_fall;

   audio_frame_fifo #(
      .DATA_W (2*AUDIO_WIDTH),
      .DEPTH  (BUFFER_DEPTH)
   ) u_fifo (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .wr_data  ({sample_in_l, sample_in_r}),
      .wr_valid (sample_wr_valid),
      .wr_ready (sample_wr_ready),
      .rd_en    (fifo_pop),
      .rd_data  (fifo_rd),
      .count    (buffer_count),
      .empty    (buffer_empty)
   );

   // Samples are left-justified in their slot with zero padding below.
   always_comb begin
      slot_l = '0;
      slot_r = '0;
      slot_l[I2S_WIDTH-1 -: AUDIO_WIDTH] = fifo_rd[2*AUDIO_WIDTH-1 -: AUDIO_WIDTH];
      slot_r[I2S_WIDTH-1 -: AUDIO_WIDTH] = fifo_rd[AUDIO_WIDTH-1:0];
   end
   assign fifo_frame = {slot_l, slot_r};

`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
   logic [FRAME_BITS-1:0] hold_frame, hold_d;
   assign underrun_frame = hold_frame;
`else
   assign underrun_frame = '0;
`endif

   always_comb begin
      state_d     = state;
      div_cnt_d   = div_cnt;
      bit_pos_d   = bit_pos;
      bclk_d      = i2s_bclk;
      lrclk_d     = i2s_lrclk;
      data_d      = i2s_data;
      shift_reg_d = shift_reg;
      underrun_d  = underrun_clr ? 1'b0 : underrun;
      fifo_pop    = 1'b0;
      load_frame  = fifo_frame;
      next_pos    = (bit_pos == POS_LAST) ? '0 : bit_pos + 1'b1;
      bclk_fall   = (div_cnt == DIV_LAST) && i2s_bclk;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
      hold_d      = hold_frame;
`endif
      case (state)
         IDLE: begin
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            data_d  = 1'b0;
            if (tx_enable) begin
               state_d   = RUN;
               bit_pos_d = POS_LAST;
               div_cnt_d = '0;
            end
         end
         RUN: begin
            div_cnt_d = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_LAST) bclk_d = ~i2s_bclk;
            if (bclk_fall) begin
               bit_pos_d = next_pos;
               // LRCLK switches one bit ahead of the slot it announces.
               lrclk_d   = ~((next_pos == POS_LAST) || (next_pos < LEFT_LAST));
               if (bit_pos == POS_LAST) begin
                  if (!tx_enable) begin
                     state_d = IDLE;
                     lrclk_d = 1'b0;
                     data_d  = 1'b0;
                  end else begin
                     if (!buffer_empty) begin
                        fifo_pop = 1'b1;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
                        hold_d   = fifo_frame;
`endif
                     end else begin
                        underrun_d = 1'b1;
                        load_frame = underrun_frame;
                     end
                     data_d      = load_frame[FRAME_BITS-1];
                     shift_reg_d = load_frame << 1;
                  end
               end else begin
                  data_d      = shift_reg[FRAME_BITS-1];
                  shift_reg_d = shift_reg << 1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_pos    <= '0;
         i2s_bclk   <= 1'b0;
         i2s_lrclk  <= 1'b0;
         i2s_data   <= 1'b0;
         underrun   <= 1'b0;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
         hold_frame <= '0;
`endif
      end else begin
         state      <= state_d;
         div_cnt    <= div_cnt_d;
         bit_pos    <= bit_pos_d;
         i2s_bclk   <= bclk_d;
         i2s_lrclk  <= lrclk_d;
         i2s_data   <= data_d;
         underrun   <= underrun_d;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
         hold_frame <= hold_d;
`endif
      end
   end

   always_ff @(posedge sys_clk) begin
      shift_reg <= shift_reg_d;
   end

endmodule

// File: doc/i2s_tx_out.md
Name: i2s_tx_out

Overview:
- Stereo I2S master transmitter; output-side counterpart of the buffered I2S receiver.
- Accepts left/right sample pairs from the processing core in the sys_clk domain and buffers them in a small frame FIFO.
- Generates BCLK and LRCLK from sys_clk and serializes each frame MSB-first in standard I2S format, with a one-BCLK data delay after each LRCLK edge.
- Drives the DAC/codec pins directly.

Parameters:
- I2S_WIDTH, 24, bits per slot; frame = 2*I2S_WIDTH BCLKs.
- AUDIO_WIDTH, 24, sample width; must be <= I2S_WIDTH (elaboration error otherwise).
- BUFFER_DEPTH, 4, frame FIFO depth; power of 2, >= 2.
- BCLK_DIV, 4, sys_clk cycles per BCLK half-period; >= 2.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  synchronous active-low reset
- tx_enable  in  1  run request; sampled at frame boundaries
- sample_in_l  in  AUDIO_WIDTH  left sample
- sample_in_r  in  AUDIO_WIDTH  right sample
- sample_wr_valid  in  1  frame write request
- sample_wr_ready  out  1  FIFO not full
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_data  out  1  serial data
- buffer_count  out  $clog2(BUFFER_DEPTH)+1  frames stored
- buffer_empty  out  1  buffer_count == 0
- underrun  out  1  sticky; frame requested while FIFO empty
- underrun_clr  in  1  clears underrun

Behaviour:
- Reset is synchronous and active-low; one clock (sys_clk).
- Values while sys_rst_n=0: all outputs 0 except sample_wr_ready=1 and buffer_empty=1. FIFO pointers, buffer_count and div_cnt are 0; state is IDLE.
- FIFO write:
  - A frame {l,r} is pushed when sample_wr_valid && sample_wr_ready.
  - sample_wr_ready = (buffer_count < BUFFER_DEPTH), taken from the registered count. A write is refused when full even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap mod BUFFER_DEPTH.
- Divider:
  - In RUN, div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1, i2s_bclk toggles.
  - BCLK period = 2*BCLK_DIV sys_clk cycles.
  - All serial-side updates occur on the sys_clk cycle in which bclk toggles 1->0 (falling edge). The receiver samples on the rising edge.
- Bit position p (0..2*I2S_WIDTH-1) advances mod 2*I2S_WIDTH on each falling edge.
  - Data: i2s_data = shift_reg MSB for position p. Slot 0 (p < I2S_WIDTH) carries left; slot 1 carries right.
  - LRCLK leads data by one bit: i2s_lrclk = 0 when p == 2*I2S_WIDTH-1 or p < I2S_WIDTH-1, else 1.
- Frame load, on the falling edge where p wraps to 0:
  - If the FIFO is non-empty: pop it; shift_reg <= {l,{PAD{0}}, r,{PAD{0}}}, where PAD = I2S_WIDTH-AUDIO_WIDTH (left-justified, zero-padded).
  - If the FIFO is empty: load zeros and set underrun.
  - underrun stays set until underrun_clr. If the set and clear coincide, set wins.
- States:
  - IDLE: bclk, lrclk and data held 0; FIFO still accepts writes.
  - IDLE->RUN when tx_enable=1: p preset to 2*I2S_WIDTH-1, div_cnt=0. The first falling edge loads a frame.
  - RUN->IDLE when tx_enable=0 at the falling edge that would wrap p to 0. No pop occurs and the current frame completes; partial frames are never emitted.
- Reset in any state returns to the reset values immediately; FIFO contents are discarded.

Optional Feature:
- Macro I2S_TX_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, the last transmitted frame is reloaded (repeat-hold) instead of zeros; underrun is still set. Hold register resets to 0.
- Undefined: zeros are sent on underrun.

Decomposition:
- Package i2s_pkg holds:
  - typedef stereo_frame_t (packed struct l/r, AUDIO_WIDTH each);
  - typedef tx_state_e {IDLE, RUN};
  - localparam helpers for frame bit count.
- One sub-module is natural: audio_frame_fifo (synchronous FIFO of stereo_frame_t, depth BUFFER_DEPTH, count output). The serializer and divider stay in the top module.

Test Plan:
- Reset mid-frame: reset asserted during RUN at p=10 -> next cycle bclk=lrclk=data=0, buffer_count=0, sample_wr_ready=1.
- Basic frame: I2S_WIDTH=24, BCLK_DIV=4; push L=0xA5F00F, R=0x5A0FF0; tx_enable=1 -> receiver model decodes identical L/R. The LRCLK edge precedes the MSB by 8 sys_clk. Frame length is 384 sys_clk.
- Full FIFO: push 5 frames back-to-back while IDLE -> 4 accepted, sample_wr_ready=0 on the 5th, buffer_count=4. After the first pop, ready=1 again.
- Underrun: enable with 1 frame queued -> frame 1 transmitted, frame 2 all zeros (with hold macro: frame 1 repeated). underrun=1 and stays set until underrun_clr.
- Stop at boundary: deassert tx_enable at p=5 -> the frame completes all 48 bits, then IDLE with outputs 0. The queued frame is retained (buffer_count unchanged).
- Padding: AUDIO_WIDTH=16, I2S_WIDTH=24, L=0x8001 -> slot bits = 0x800100.
